oled_spi_writer: RTL

- Byte-level SPI transmit stage for the 128x32 SSD1306-class OLED.
- Sits between the init/refresh sequencer and the OLED pins (csn, dcn, clk, dat).
- Accepts command/data bytes through a valid/ready interface into a small FIFO.
- Serialises each byte MSB-first with the D/C line set, keeping chip-select low across back-to-back bytes.

---
 rtl/oled_spi_writer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/oled_spi_writer.sv
// Byte-level SPI transmit stage for an SSD1306-class OLED: a small valid/ready FIFO feeding an
// MSB-first serialiser that keeps chip-select low across back-to-back bytes.
module oled_spi_writer #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CS_HOLD    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_byte,
   input  logic       in_dc,
   output logic       busy,
   output logic       oled_csn,
   output logic       oled_dcn,
   output logic       oled_clk,
   output logic       oled_dat
);

   localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned HoldW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
   localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
   localparam logic [HoldW-1:0] HoldLast = HoldW'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);
   localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StSetup, StLow, StHigh, StHold} state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [HoldW-1:0]  hold_q, hold_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        sr_q, sr_d;
   logic              csn_q, csn_d;
   logic              sclk_q, sclk_d;
   logic              dat_q, dat_d;
   logic              dcn_q, dcn_d;
   logic [PtrW-1:0]   wptr_q, wptr_d;
   logic [PtrW-1:0]   rptr_q, rptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [8:0]        mem_q [FIFO_DEPTH];
   logic [8:0]        mem_d [FIFO_DEPTH];
   logic [8:0]        head;
   logic              push;
   logic              pop;

   assign in_ready = !rst && (count_q != CntFull);
   assign push     = in_valid && in_ready;
   assign busy     = !rst && ((count_q != '0) || (state_q != StIdle));
   assign head     = mem_q[rptr_q];

   assign oled_csn = csn_q;
   assign oled_dcn = dcn_q;
   assign oled_clk = sclk_q;
   assign oled_dat = dat_q;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         mem_d[wptr_q] = {in_dc, in_byte};
         wptr_d        = wptr_q + PtrW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PtrW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      hold_d  = hold_q;
      bit_d   = bit_q;
      sr_d    = sr_q;
      csn_d   = csn_q;
      sclk_d  = sclk_q;
      dat_d   = dat_q;
      dcn_d   = dcn_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            csn_d  = 1'b1;
            sclk_d = 1'b1;
            if (count_q != '0) begin
               pop     = 1'b1;
               sr_d    = head[7:0];
               dcn_d   = head[8];
               dat_d   = head[7];
               csn_d   = 1'b0;
               div_d   = '0;
               bit_d   = '0;
               state_d = StSetup;
            end
         end
         StSetup: begin
            if (div_q == DivLast) begin
               div_d   = '0;
               sclk_d  = 1'b0;
               state_d = StLow;
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StLow: begin
            if (div_q == DivLast) begin
               div_d   = '0;
               sclk_d  = 1'b1;
               state_d = StHigh;
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StHigh: begin
            if (div_q == DivLast) begin
               div_d = '0;
               if (bit_q != 3'd7) begin
                  bit_d   = bit_q + 3'd1;
                  sr_d    = {sr_q[6:0], 1'b0};
                  dat_d   = sr_q[6];
                  sclk_d  = 1'b0;
                  state_d = StLow;
               end else if (count_q != '0) begin
                  // Chain straight into the next byte; csn stays low, clk stays high.
                  pop     = 1'b1;
                  sr_d    = head[7:0];
                  dcn_d   = head[8];
                  dat_d   = head[7];
                  bit_d   = '0;
                  state_d = StSetup;
               end else begin
                  hold_d  = '0;
                  state_d = StHold;
               end
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StHold: begin
            if (hold_q == HoldLast) begin
               csn_d   = 1'b1;
               state_d = StIdle;
            end else begin
               hold_d = hold_q + HoldW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         div_q   <= '0;
         hold_q  <= '0;
         bit_q   <= '0;
         sr_q    <= '0;
         csn_q   <= 1'b1;
         sclk_q  <= 1'b1;
         dat_q   <= 1'b0;
         dcn_q   <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         hold_q  <= hold_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         csn_q   <= csn_d;
         sclk_q  <= sclk_d;
         dat_q   <= dat_d;
         dcn_q   <= dcn_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
